// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  // Returns the first set request scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  // The loop runs from the farthest candidate to the nearest, so the nearest
  // set bit is the one written last and wins. The 2-bit index wraps for free.
  // Callers only use the result when req is non-zero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] cand;
    rr_pick = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) rr_pick = cand;
    end
  endfunction

endpackage

// File: rtl/arb_onehot_dec.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when en=0.
// Latency: combinational.
// Backpressure: none.
// Ports: en (enable), idx[1:0] (index to decode), oh[3:0] (one-hot result).
module arb_onehot_dec
  import rr_arb_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] oh
);

  always_comb begin
    oh = '0;
    if (en) oh[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter, 4 requesters, locked grant held until the owner releases.
// Latency: grant rises 1 cycle after req is sampled in IDLE; one IDLE cycle between grants.
// Backpressure: other requesters wait while BUSY; release on done or owner withdrawing req.
// Ports: clk, rst (sync, active-high), req[3:0], done -> grant[3:0], gnt_idx[1:0],
//        gnt_valid, timeout.
// Optional: define RR_ARB_TIMEOUT_EN to force a release after MAX_HOLD BUSY cycles
//           (timeout pulses for one cycle); otherwise timeout is tied low.
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;       // last owner; lowest priority on the next pick
  logic             owner_rel; // owner asked to give up the resource
  logic             force_rel; // hold limit reached with no owner release

  // Both release causes in the same cycle collapse into a single release.
  assign owner_rel = done | ~req[gnt_idx];

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  assign force_rel = (hold_cnt == CNT_W'(MAX_HOLD - 1)) & ~owner_rel;
  assign timeout   = timeout_q;
`else
  // Without the hold limit the parameter has no consumer; this keeps it referenced.
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD > 0);

  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= IDX_W'(N_REQ - 1);
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // done is deliberately not looked at here.
          if (|req) begin
            gnt_idx   <= rr_pick(req, ptr);
            gnt_valid <= 1'b1;
            state     <= BUSY;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        BUSY: begin
          if (owner_rel | force_rel) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx;
`ifdef RR_ARB_TIMEOUT_EN
            timeout_q <= force_rel;
`endif
          end else begin
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt  <= hold_cnt + 1'b1;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  // gnt_valid mirrors the BUSY state, so grant is zero whenever IDLE.
  arb_onehot_dec u_dec (
    .en  (gnt_valid),
    .idx (gnt_idx),
    .oh  (grant)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

`ifdef RR_ARB_TIMEOUT_EN
  rr_arbiter_4 #(.MAX_HOLD(4)) dut (
`else
  rr_arbiter_4 dut (
`endif
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; done = 1'b0;
    tick(); tick();
    checks++;
    if (grant !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: grant=%b valid=%b idx=%0d timeout=%b, want 0000/0/0/0",
               grant, gnt_valid, gnt_idx, timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    logic [1:0] exp_seq [5];
    logic [3:0] exp_oh;
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_oh = 4'b0001 << exp_seq[i];
      checks++;
      if (grant !== exp_oh || gnt_idx !== exp_seq[i] || gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation_grant[%0d]: grant=%b idx=%0d valid=%b, want %b/%0d/1",
                 i, grant, gnt_idx, gnt_valid, exp_oh, exp_seq[i]);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (grant !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== exp_seq[i]) begin
        errors++;
        $display("FAIL rotation_gap[%0d]: grant=%b valid=%b idx=%0d, want 0000/0/%0d",
                 i, grant, gnt_valid, gnt_idx, exp_seq[i]);
      end
    end
  endtask

  task automatic test_skip_wrap();
    // Fresh reset leaves ptr=3; first grant goes to requester 2.
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    tick();
    rst = 1'b0; req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL skip_setup: grant=%b, want 0100", grant);
    end
    // Owner withdraws: release with ptr=2, then scan 3,0 -> requester 0.
    req = 4'b0011;
    tick();
    checks++;
    if (grant !== 4'b0000 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_release: grant=%b valid=%b, want 0000/0", grant, gnt_valid);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL skip_wrap: grant=%b idx=%0d, want 0001/0", grant, gnt_idx);
    end
    req = 4'b0010;
    tick(); tick();
    checks++;
    if (grant !== 4'b0010 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL skip_only1: grant=%b idx=%0d, want 0010/1", grant, gnt_idx);
    end
  endtask

  task automatic test_withdraw_done();
    // Owner 1 drops req and pulses done together: exactly one release, ptr=1.
    req = 4'b1101; done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (grant !== 4'b0000 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_release: grant=%b valid=%b, want 0000/0", grant, gnt_valid);
    end
    tick();
    checks++;
    if (grant !== 4'b0100 || gnt_idx !== 2'd2) begin
      errors++;
      $display("FAIL simul_next: grant=%b idx=%0d, want 0100/2", grant, gnt_idx);
    end
  endtask

  task automatic test_reset_mid_grant();
    // Owner 2 holds; reset must drop grant at that edge and restore ptr=3.
    rst = 1'b1; req = 4'b0101;
    tick();
    checks++;
    if (grant !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: grant=%b valid=%b idx=%0d, want 0000/0/0",
               grant, gnt_valid, gnt_idx);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0001 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_next: grant=%b idx=%0d, want 0001/0", grant, gnt_idx);
    end
  endtask

  task automatic test_idle_done();
    // Release owner 0, then hold req low with done high: nothing may be granted.
    req = 4'b0000; done = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (grant !== 4'b0000 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_done: grant=%b valid=%b, want 0000/0", grant, gnt_valid);
    end
    done = 1'b0;
    // ptr=0 now: scan 1,2,3,0 with req 0101 -> requester 2.
    req = 4'b0101;
    tick();
    checks++;
    if (grant !== 4'b0100 || gnt_idx !== 2'd2) begin
      errors++;
      $display("FAIL idle_done_next: grant=%b idx=%0d, want 0100/2", grant, gnt_idx);
    end
  endtask

  task automatic test_hold();
    int bad;
    // Owner 2 was granted at the previous edge (first BUSY cycle now).
    bad = 0;
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (grant !== 4'b0100 || timeout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_before_limit: %0d bad cycles, want grant 0100 timeout 0", bad);
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL forced_release: grant=%b timeout=%b, want 0000/1", grant, timeout);
    end
    // ptr=2: scan 3,0 -> requester 0.
    tick();
    checks++;
    if (grant !== 4'b0001 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout: grant=%b timeout=%b, want 0001/0", grant, timeout);
    end
`else
    for (int i = 0; i < 60; i++) begin
      tick();
      if (grant !== 4'b0100 || timeout !== 1'b0 || gnt_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_forever: %0d bad cycles out of 60, want grant 0100 timeout 0", bad);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_withdraw_done();
    test_reset_mid_grant();
    test_idle_done();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
